axi_wr_channel_fsm: RTL

- Parametrised AXI4 write-path master FSM; next generation of the single-slot AW/W/B protocol FSM.
- Accepts write commands and write data from an upstream client and drives AW, W and B channels with full AXI valid/ready stability.
- Supports up to DEPTH outstanding bursts, generates WLAST from a per-burst beat counter, and tracks responses by ID.
- Sits between the client traffic generator and the AXI interconnect port under verification.

---
 rtl/axi_pkg.sv | 31 +++
 rtl/axi_wr_channel_fsm_if.sv | 46 ++++
 rtl/axi_len_fifo.sv | 49 ++++
 rtl/axi_wr_channel_fsm.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the width-independent part of the AW payload
// for the write-channel master.
package axi_pkg;

    localparam logic [1:0] FIXED      = 2'b00;
    localparam logic [1:0] INCR       = 2'b01;
    localparam logic [1:0] WRAP       = 2'b10;
    localparam logic [1:0] BURST_RSVD = 2'b11;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } aw_payload_t;

    typedef enum logic {
        AW_IDLE,
        AW_PEND
    } aw_state_e;

    // SLVERR and DECERR are exactly the responses with bit 1 set.
    function automatic logic is_err_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_wr_channel_fsm_if.sv
// AXI4 write-path channels (AW, W, B) between the write master and the
// interconnect port.
interface axi_wr_channel_fsm_if #(
    parameter int AW  = 32,
    parameter int DW  = 64,
    parameter int IDW = 4
);

    logic [AW-1:0]   axi_awaddr;
    logic [IDW-1:0]  axi_awid;
    logic [7:0]      axi_awlen;
    logic [2:0]      axi_awsize;
    logic [1:0]      axi_awburst;
    logic            axi_awvalid;
    logic            axi_awready;

    logic [DW-1:0]   axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic            axi_wlast;
    logic            axi_wvalid;
    logic            axi_wready;

    logic [IDW-1:0]  axi_bid;
    logic [1:0]      axi_bresp;
    logic            axi_bvalid;
    logic            axi_bready;

    modport master (
        output axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready
    );

    modport slave (
        input  axi_awaddr, axi_awid, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready
    );

endinterface

// File: rtl/axi_len_fifo.sv
// Burst-length FIFO: one entry per accepted burst whose data is still owed.
// Push while full is accepted only together with a pop.
module axi_len_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         axi_aclk,
    input  logic         axi_areset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge axi_aclk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/axi_wr_channel_fsm.sv
// AXI4 write-path master: registered AW/W stages, up to DEPTH outstanding
// bursts, WLAST from a per-burst beat counter, B responses tracked by ID.
module axi_wr_channel_fsm
    import axi_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 64,
    parameter int IDW   = 4,
    parameter int DEPTH = 4
) (
    input  logic                   axi_aclk,
    input  logic                   axi_areset,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [IDW-1:0]         cmd_id,
    input  logic [7:0]             cmd_len,
    input  logic [2:0]             cmd_size,
    input  logic [1:0]             cmd_burst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [DW-1:0]          wdata_in,
    input  logic [DW/8-1:0]        wstrb_in,
    input  logic                   wvalid_in,
    output logic                   wready_out,
    axi_wr_channel_fsm_if.master   axi,
    output logic                   done_valid,
    output logic [IDW-1:0]         done_id,
    output logic [1:0]             done_resp,
    output logic [$clog2(DEPTH):0] inflight,
    output logic                   err_resp,
    output logic                   err_proto
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    aw_state_e       aw_state;
    aw_state_e       aw_state_nxt;
    logic [AW-1:0]   awaddr_q;
    logic [IDW-1:0]  awid_q;
    aw_payload_t     aw_q;

    logic            cmd_fire;
    logic            cmd_rsvd;
    logic            cmd_push;

    logic            wvalid_q;
    logic            wlast_q;
    logic [DW-1:0]   wdata_q;
    logic [DW/8-1:0] wstrb_q;
    logic [7:0]      beat_cnt;
    logic [7:0]      head_len;
    logic            beat_last;
    logic            w_accept;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            b_fire;

    // ---------------- command / AW channel ----------------
    assign cmd_ready = (!axi.axi_awvalid || axi.axi_awready) && (inflight < DEPTH_C);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign cmd_rsvd  = (cmd_burst == BURST_RSVD);
    assign cmd_push  = cmd_fire && !cmd_rsvd;

    always_ff @(posedge axi_aclk) begin
        // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (axi_areset) aw_state <= AW_IDLE;
        else            aw_state <= aw_state_nxt;
    end

    always_comb begin
        // NOTE: next-state gets a default first, so no path through the block can infer a latch.
        aw_state_nxt = aw_state;
        case (aw_state)
            AW_IDLE: if (cmd_push) aw_state_nxt = AW_PEND;
            AW_PEND: if (!cmd_push && axi.axi_awready) aw_state_nxt = AW_IDLE;
            default: aw_state_nxt = AW_IDLE;
        endcase
    end

    // A new command can only load while AW is idle or handshaking this cycle,
    // so the presented payload never changes under a stalled awvalid.
    always_ff @(posedge axi_aclk) begin
        if (cmd_push) begin
            awaddr_q <= cmd_addr;
            awid_q   <= cmd_id;
            aw_q     <= '{len: cmd_len, size: cmd_size, burst: cmd_burst};
        end
    end

    assign axi.axi_awvalid = (aw_state == AW_PEND);
    assign axi.axi_awaddr  = awaddr_q;
    assign axi.axi_awid    = awid_q;
    assign axi.axi_awlen   = aw_q.len;
    assign axi.axi_awsize  = aw_q.size;
    assign axi.axi_awburst = aw_q.burst;

    // ---------------- W channel ----------------
    axi_len_fifo #(.DEPTH(DEPTH), .W(8)) u_len_fifo (
        .axi_aclk   (axi_aclk),
        .axi_areset (axi_areset),
        .push       (cmd_push),
        .push_data  (cmd_len),
        .pop        (fifo_pop),
        .head       (head_len),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Data is gated on a queued length, so it may run ahead of AW but never
    // ahead of command acceptance.
    assign wready_out = (!wvalid_q || axi.axi_wready) && !fifo_empty;
    assign w_accept   = wvalid_in && wready_out;
    assign beat_last  = (beat_cnt == head_len);
    assign fifo_pop   = w_accept && beat_last;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            beat_cnt <= '0;
        end else if (w_accept) begin
            wvalid_q <= 1'b1;
            wlast_q  <= beat_last;
            beat_cnt <= beat_last ? 8'd0 : beat_cnt + 8'd1;
        end else if (axi.axi_wready) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (w_accept) begin
            wdata_q <= wdata_in;
            wstrb_q <= wstrb_in;
        end
    end

    assign axi.axi_wvalid = wvalid_q;
    assign axi.axi_wlast  = wlast_q;
    assign axi.axi_wdata  = wdata_q;
    assign axi.axi_wstrb  = wstrb_q;

    // ---------------- B channel / bookkeeping ----------------
    assign axi.axi_bready = (inflight != '0);
    assign b_fire         = axi.axi_bvalid && axi.axi_bready;

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            inflight   <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_resp  <= OKAY;
            err_resp   <= 1'b0;
            err_proto  <= 1'b0;
        end else begin
            inflight   <= inflight + CW'(cmd_push) - CW'(b_fire);
            done_valid <= b_fire;
            if (b_fire) begin
                done_id   <= axi.axi_bid;
                done_resp <= axi.axi_bresp;
            end
            err_resp <= err_resp || (b_fire && is_err_resp(axi.axi_bresp));
            // A length push into a full FIFO means B came back before its data drained.
            err_proto <= err_proto
                      || (cmd_fire && cmd_rsvd)
                      || (axi.axi_bvalid && inflight == '0)
                      || (cmd_push && fifo_full && !fifo_pop);
        end
    end

endmodule
